instr_fetch_unit: RTL and testbench

//   Fetch stage that sits directly upstream of the multicycle decode/control FSM.

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads words over a req/ack bus and
// presents them to decode through a valid/ready instruction register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned    CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]    NOP       = 32'h0000_0013;
  localparam logic [1:0]     CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]     CAUSE_BUS_ERR  = 2'b10;
  localparam logic [1:0]     CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            imem_req_q, imem_req_d;
  logic [31:0]     imem_addr_q, imem_addr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instr_pc_q, instr_pc_d;
  logic            fetch_fault_q, fetch_fault_d;
  logic [1:0]      fault_cause_q, fault_cause_d;
  logic            redirect_ok, redirect_bad;

  assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    wait_d        = wait_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_fault_d = fetch_fault_q;
    fault_cause_d = fault_cause_q;

    if (redirect_bad) begin
      // A misaligned target is fatal from any state, even mid-transaction.
      state_d       = S_FAULT;
      imem_req_d    = 1'b0;
      instr_valid_d = 1'b0;
      fetch_fault_d = 1'b1;
      fault_cause_d = CAUSE_MISALIGN;
      kill_d        = 1'b0;
      wait_d        = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = redirect_ok ? redirect_pc : pc_q;
          pc_d        = redirect_ok ? redirect_pc : pc_q;
          wait_d      = '0;
        end

        S_REQ: begin
          if (imem_ack) begin
            wait_d = '0;
            if (redirect_ok) begin
              pc_d        = redirect_pc;
              kill_d      = 1'b0;
              imem_addr_d = redirect_pc;
            end else if (kill_q) begin
              // Stale response for a redirected-away fetch: discard and refetch.
              kill_d      = 1'b0;
              imem_addr_d = pc_q;
            end else if (imem_err) begin
              state_d       = S_FAULT;
              imem_req_d    = 1'b0;
              fetch_fault_d = 1'b1;
              fault_cause_d = CAUSE_BUS_ERR;
            end else begin
              state_d       = S_HOLD;
              imem_req_d    = 1'b0;
              instr_valid_d = 1'b1;
              instr_d       = imem_rdata;
              instr_pc_d    = pc_q;
              pc_d          = pc_q + 32'd4;
            end
          end else if (redirect_ok) begin
            // The bus cycle cannot be aborted, so keep it and mark it stale.
            pc_d   = redirect_pc;
            kill_d = 1'b1;
            wait_d = '0;
          end else if (wait_q == WAIT_LAST) begin
            state_d       = S_FAULT;
            imem_req_d    = 1'b0;
            fetch_fault_d = 1'b1;
            fault_cause_d = CAUSE_TIMEOUT;
            kill_d        = 1'b0;
            wait_d        = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect_ok || instr_ready) begin
            state_d       = S_REQ;
            instr_valid_d = 1'b0;
            imem_req_d    = 1'b1;
            imem_addr_d   = redirect_ok ? redirect_pc : pc_q;
            pc_d          = redirect_ok ? redirect_pc : pc_q;
            wait_d        = '0;
          end
        end

        S_FAULT: begin
          if (redirect_ok) begin
            state_d       = S_REQ;
            fetch_fault_d = 1'b0;
            fault_cause_d = 2'b00;
            imem_req_d    = 1'b1;
            imem_addr_d   = redirect_pc;
            pc_d          = redirect_pc;
            wait_d        = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      wait_q        <= '0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= 32'h0000_0000;
      fetch_fault_q <= 1'b0;
      fault_cause_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      wait_q        <= wait_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_fault_q <= fetch_fault_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed handshake/fault scenarios followed by a
// randomized run against a program-order model of the delivered instruction stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, reset_w;
  logic        imem_ack, imem_err, instr_ready, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;

  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [1:0]  fault_cause;

  logic        w_imem_req, w_instr_valid, w_fetch_fault;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc;
  logic [1:0]  w_fault_cause;

  int compared   = 0;
  int mismatched = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_w (
    .clk(clk), .reset(reset_w),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready),
    .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(w_fetch_fault), .fault_cause(w_fault_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_2468;
  endfunction

  task automatic idle_inputs();
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
  endtask

  logic        pending;
  int          wait_left;
  logic [31:0] lat_addr, exp_pc;
  int          delivered;

  initial begin
    reset = 1'b1; reset_w = 1'b1;
    idle_inputs();

    // 1. reset state and a zero-wait fetch
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_cause", fault_cause, 0);
    reset = 1'b0;
    tick();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    tick();
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_instr_pc", instr_pc, 32'h0);
    chk("t1_req_hold", imem_req, 0);
    imem_ack = 1'b0;
    tick();
    chk("t1_next_req", imem_req, 1);
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t1_valid_drop", instr_valid, 0);

    // 2. decode back-pressure
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113; instr_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr, 32'h00A0_0113);
      chk("t2_instr_pc", instr_pc, 32'h4);
      chk("t2_req_low", imem_req, 0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_req", imem_req, 1);
    chk("t2_addr", imem_addr, 32'h8);
    chk("t2_valid_drop", instr_valid, 0);
    instr_ready = 1'b0;

    // 3. redirect while a request waits
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_req_kept", imem_req, 1);
    chk("t3_addr_kept", imem_addr, 32'h8);
    tick();
    chk("t3_addr_kept2", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t3_req_new", imem_req, 1);
    chk("t3_addr_new", imem_addr, 32'h100);
    chk("t3_no_valid", instr_valid, 0);
    imem_rdata = 32'h0010_0113;
    tick();
    chk("t3_valid", instr_valid, 1);
    chk("t3_instr", instr, 32'h0010_0113);
    chk("t3_instr_pc", instr_pc, 32'h100);
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    chk("t3_next_addr", imem_addr, 32'h104);
    instr_ready = 1'b0;

    // 4. misaligned redirect then recovery
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    chk("t4_fault", fetch_fault, 1);
    chk("t4_cause", fault_cause, 2'b01);
    chk("t4_req", imem_req, 0);
    redirect_valid = 1'b0;
    tick();
    chk("t4_fault_sticky", fetch_fault, 1);
    chk("t4_req_sticky", imem_req, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("t4_clear", fetch_fault, 0);
    chk("t4_cause_clear", fault_cause, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);

    // 5. redirect coinciding with ack, bus error, timeouts
    redirect_pc = 32'hC; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    chk("t5_req_c", imem_req, 1);
    chk("t5_addr_c", imem_addr, 32'hC);
    chk("t5_no_valid", instr_valid, 0);
    redirect_valid = 1'b0; imem_err = 1'b1;
    tick();
    chk("t5_err_fault", fetch_fault, 1);
    chk("t5_err_cause", fault_cause, 2'b10);
    chk("t5_err_valid", instr_valid, 0);
    chk("t5_err_req", imem_req, 0);
    imem_ack = 1'b0; imem_err = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    chk("t5_to_addr", imem_addr, 32'h20);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_to_waiting", imem_req, 1);
    end
    tick();
    chk("t5_to_req", imem_req, 0);
    chk("t5_to_cause", fault_cause, 2'b11);
    chk("t5_to_fault", fetch_fault, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("t5_kill_addr", imem_addr, 32'h40);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_kill_waiting", imem_req, 1);
    end
    tick();
    chk("t5_kill_to_req", imem_req, 0);
    chk("t5_kill_to_cause", fault_cause, 2'b11);

    // 6. wrapping reset PC and reset during a wait
    idle_inputs();
    tick();
    reset_w = 1'b0;
    tick();
    chk("t6_req", w_imem_req, 1);
    chk("t6_addr", w_imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073; instr_ready = 1'b1;
    tick();
    chk("t6_valid", w_instr_valid, 1);
    chk("t6_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    imem_ack = 1'b0;
    tick();
    chk("t6_wrap_addr", w_imem_addr, 32'h0);
    chk("t6_wrap_fault", w_fetch_fault, 0);
    tick();
    reset_w = 1'b1;
    tick();
    chk("t6_rst_req", w_imem_req, 0);
    chk("t6_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
    reset_w = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("t6_late_ack_valid", w_instr_valid, 0);
    chk("t6_late_ack_req", w_imem_req, 1);
    imem_ack = 1'b0;
    tick();
    chk("t6_late_ack_valid2", w_instr_valid, 0);
    chk("t6_late_ack_instr", w_instr, 32'h0000_0013);

    // randomized run: random memory latency, back-pressure and redirects
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = 32'h0; pending = 1'b0; wait_left = 0; lat_addr = 32'h0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_no_fault", fetch_fault, 0);
      chk("rnd_req_xor_valid", imem_req & instr_valid, 0);
      if (!imem_req) begin
        pending = 1'b0;
        imem_ack = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1'b1;
          lat_addr = imem_addr;
          wait_left = $urandom_range(0, 3);
        end else begin
          chk("rnd_addr_stable", imem_addr, lat_addr);
        end
        if (wait_left == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(lat_addr);
          pending = 1'b0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = $urandom;
          wait_left--;
        end
      end
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
      instr_ready = ($urandom_range(0, 3) != 0);
      // Program-order model: a redirect defines the next PC, otherwise each
      // accepted instruction must be the word at the expected PC.
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        chk("rnd_instr_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    chk("rnd_progress", 32'(delivered > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
